// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one external 2-bit ALU among NUM_REQ
//            requesters; define ARB_PERF_CNT_EN to build the perf counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_a,
  input  logic [2*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  input  logic [3*NUM_REQ-1:0] req_ctrl,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic [1:0]           alu_a,
  output logic [1:0]           alu_b,
  output logic                 alu_cin,
  output logic [2:0]           alu_ctrl,
  input  logic [3:0]           alu_result,
  output logic [15:0]          perf_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      data_q, data_d;
  logic [1:0]      alu_a_q, alu_a_d;
  logic [1:0]      alu_b_q, alu_b_d;
  logic            alu_cin_q, alu_cin_d;
  logic [2:0]      alu_ctrl_q, alu_ctrl_d;

  logic               w_lo_vld, w_hi_vld;
  logic [ID_W-1:0]    w_lo_id, w_hi_id, w_grant_id;
  logic [1:0]         w_sel_a, w_sel_b;
  logic               w_sel_cin;
  logic [2:0]         w_sel_ctrl;

  // Lowest requester at/above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_lo_vld = 1'b0;
    w_lo_id  = '0;
    w_hi_vld = 1'b0;
    w_hi_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_vld = 1'b1;
        w_lo_id  = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          w_hi_vld = 1'b1;
          w_hi_id  = ID_W'(i);
        end
      end
    end
    w_grant_id = w_hi_vld ? w_hi_id : w_lo_id;
  end

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_cin  = 1'b0;
    w_sel_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_a    = req_a[2*i +: 2];
        w_sel_b    = req_b[2*i +: 2];
        w_sel_cin  = req_cin[i];
        w_sel_ctrl = req_ctrl[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    data_d     = data_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_ctrl_d = alu_ctrl_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (w_lo_vld && !rst) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (w_grant_id == ID_W'(i));
          end
          alu_a_d    = w_sel_a;
          alu_b_d    = w_sel_b;
          alu_cin_d  = w_sel_cin;
          alu_ctrl_d = w_sel_ctrl;
          id_d       = w_grant_id;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = alu_result;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      data_q     <= data_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_ctrl  = alu_ctrl_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (rsp_valid && rsp_ready && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_count = perf_q;
`else
  assign perf_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Self-checking bench for alu_share_arbiter with a transaction-level
//            reference model and a bench-side ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_cin;
  logic [2*N-1:0]  req_a, req_b;
  logic [3*N-1:0]  req_ctrl;
  logic            rsp_valid, rsp_ready;
  logic [3:0]      rsp_data, alu_result;
  logic [IW-1:0]   rsp_id;
  logic [1:0]      alu_a, alu_b;
  logic            alu_cin;
  logic [2:0]      alu_ctrl;
  logic [15:0]     perf_count;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .perf_count(perf_count)
  );

  function automatic logic [3:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                        input logic c, input logic [2:0] op);
    case (op)
      3'd0:    return {2'b00, a & b};
      3'd1:    return {2'b00, a | b};
      3'd2:    return {2'b00, a ^ b};
      3'd3:    return {2'b00, ~a};
      3'd4:    return {2'b00, a} + {2'b00, b} + {3'b000, c};
      3'd5:    return {2'b00, a} - {2'b00, b} - {3'b000, c};
      3'd6:    return {2'b00, a} * {2'b00, b};
      default: return {a, b};
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_cin, alu_ctrl);

  // stimulus state
  logic [N-1:0] v;
  logic [1:0]   fa [N];
  logic [1:0]   fb [N];
  logic         fc [N];
  logic [2:0]   fo [N];
  logic [N-1:0] granted;
  bit           chk_en;

  // reference model: phase 0 = waiting for a request, 1 = ALU busy, 2 = response pending
  int         m_phase, m_ptr, m_id, m_done;
  logic [1:0] m_a, m_b;
  logic       m_cin;
  logic [2:0] m_ctrl;
  logic [3:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_done = 0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_ctrl = '0; m_data = '0;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && req_valid[j]) return idx;
      end
    end
    return -1;
  endfunction

  function automatic void model_edge();
    int g;
    granted = '0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        g = model_grant();
        if (g >= 0) begin
          for (int j = 0; j < N; j++) begin
            if (j == g) begin
              m_a = fa[j]; m_b = fb[j]; m_cin = fc[j]; m_ctrl = fo[j];
              granted[j] = 1'b1;
            end
          end
          m_id = g;
          m_phase = 1;
        end
      end
      1: begin
        m_data = alu_fn(m_a, m_b, m_cin, m_ctrl);
        m_phase = 2;
      end
      default: begin
        if (rsp_ready) begin
          m_ptr = (m_id + 1) % N;
          if (m_done < 65535) m_done++;
          m_phase = 0;
        end
      end
    endcase
  endfunction

  function automatic int exp_perf();
`ifdef ARB_PERF_CNT_EN
    return m_done;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs();
    int g;
    logic [N-1:0] er;
    g  = model_grant();
    er = (m_phase == 0 && g >= 0 && !rst) ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp", {27'd0, rsp_valid, rsp_data},
        {27'd0, (m_phase == 2) ? 1'b1 : 1'b0, m_data});
    if (m_phase == 2) chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("alu_bus", {24'd0, alu_a, alu_b, alu_cin, alu_ctrl},
        {24'd0, m_a, m_b, m_cin, m_ctrl});
    chk("perf_count", 32'(perf_count), 32'(exp_perf()));
  endtask

  task automatic drive();
    req_valid = v;
    for (int j = 0; j < N; j++) begin
      req_a[2*j +: 2]    = fa[j];
      req_b[2*j +: 2]    = fb[j];
      req_cin[j]         = fc[j];
      req_ctrl[3*j +: 3] = fo[j];
    end
  endtask

  task automatic peek();
    drive();
    #1;
  endtask

  task automatic cycle();
    drive();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_fields(input int j_sel);
    for (int j = 0; j < N; j++) begin
      if (j == j_sel) begin
        fa[j] = 2'($urandom); fb[j] = 2'($urandom);
        fc[j] = 1'($urandom); fo[j] = 3'($urandom);
      end
    end
  endtask

  int rr_exp [6] = '{3, 0, 1, 2, 3, 0};

  initial begin
    chk_en = 1'b0;
    granted = '0;
    model_reset();
    for (int j = 0; j < N; j++) rand_fields(j);
    rst = 1'b1; v = '1; rsp_ready = 1'b0;
    @(negedge clk);

    // reset with every requester asking
    cycle();
    chk_en = 1'b1;
    cycle();
    peek();
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_outs", {16'd0, rsp_valid, rsp_data, rsp_id, alu_a, alu_b, alu_cin, alu_ctrl},
        32'd0);

    // single add from requester 2
    rst = 1'b0; rsp_ready = 1'b1; v = 4'b0100;
    fa[2] = 2'd3; fb[2] = 2'd2; fc[2] = 1'b1; fo[2] = 3'b100;
    peek();
    chk("add_ready", 32'(req_ready), 32'h4);
    cycle();
    v = '0;
    peek();
    chk("add_exec", {27'd0, rsp_valid, alu_ctrl, alu_a}, {27'd0, 1'b0, 3'b100, 2'd3});
    cycle();
    peek();
    chk("add_rsp", {25'd0, rsp_valid, rsp_data, rsp_id}, {25'd0, 1'b1, 4'd6, 2'd2});
    cycle();

    // round-robin with all requesters held valid; pointer starts at 3
    for (int j = 0; j < N; j++) fo[j] = 3'b000;
    v = '1;
    for (int t = 0; t < 6; t++) begin
      peek();
      chk("rr_grant", 32'(req_ready), 32'(1 << rr_exp[t]));
      cycle();
      cycle();
      peek();
      chk("rr_id", 32'(rsp_id), 32'(rr_exp[t]));
      cycle();
    end
    v = '0;
    cycle();

    // backpressure on requester 1
    v = 4'b0010; rsp_ready = 1'b0;
    fa[1] = 2'd2; fb[1] = 2'd3; fc[1] = 1'b0; fo[1] = 3'b110;
    peek();
    chk("bp_ready", 32'(req_ready), 32'h2);
    cycle();
    v = '1;
    cycle();
    for (int t = 0; t < 5; t++) begin
      peek();
      chk("bp_hold", {24'd0, req_ready, rsp_valid, rsp_data, rsp_id},
          {24'd0, 4'b0000, 1'b1, 4'd6, 2'd1});
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    peek();
    chk("bp_release", {27'd0, rsp_valid, req_ready}, {27'd0, 1'b0, 4'b0100});
    v = '0;
    cycle();

    // reset during EXEC
    v = 4'b1000;
    cycle();
    v = '0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      peek();
      chk("midrst_novalid", 32'(rsp_valid), 32'd0);
      cycle();
    end
    v = '1;
    peek();
    chk("midrst_grant0", 32'(req_ready), 32'h1);
    cycle();
    v = '0;
    cycle();
    cycle();

    // ten back-to-back handshakes from a fresh reset
    rst = 1'b1;
    cycle();
    rst = 1'b0; v = 4'b0001; rsp_ready = 1'b1;
    for (int t = 0; t < 30; t++) cycle();
    v = '0;
    peek();
`ifdef ARB_PERF_CNT_EN
    chk("perf_10", 32'(perf_count), 32'd10);
`else
    chk("perf_off", 32'(perf_count), 32'd0);
`endif
    cycle();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int j = 0; j < N; j++) begin
        if (v[j] && !granted[j]) begin
          if ($urandom_range(0, 7) == 0) v[j] = 1'b0;
        end else begin
          v[j] = 1'($urandom);
          rand_fields(j);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
